// File: rtl/regfile_pkg.sv
// Shared widths and requester indices for the regfile writeback arbiter.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MDV = 1'b1;

endpackage : regfile_pkg

// File: rtl/wb_hold_slot.sv
// Single-entry holding register for one writeback requester.
// A load refills the entry; otherwise a clear empties it.
module wb_hold_slot #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    // Load wins over clear so a granted slot can refill on the same edge.
    always_comb begin
        valid_d = valid_q;
        if (load_i) begin
            valid_d = 1'b1;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: addr/data are reset too, so a reset leaves no stale payload that could leak to the write port.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (load_i) begin
                addr_q <= addr_i;
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule : wb_hold_slot

// File: rtl/regfile_wb_arbiter.sv
// Two-requester (ALU, multdiv) writeback arbiter onto a single regfile write port,
// with one holding entry per requester, round-robin grant and a pending-register mask.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [ADDR_W-1:0]    a_addr,
    input  logic [DATA_W-1:0]    a_data,
    input  logic                 m_valid,
    output logic                 m_ready,
    input  logic [ADDR_W-1:0]    m_addr,
    input  logic [DATA_W-1:0]    m_data,
    output logic                 ctrl_writeEnable,
    output logic [ADDR_W-1:0]    ctrl_writeReg,
    output logic [DATA_W-1:0]    data_writeReg,
    output logic [2**ADDR_W-1:0] pending
);

    logic              held_a, held_m;
    logic [ADDR_W-1:0] hold_addr_a, hold_addr_m;
    logic [DATA_W-1:0] hold_data_a, hold_data_m;
    logic              gnt_a, gnt_m;
    logic              load_a, load_m;
    logic              rr_q, rr_d;

    // rr_q names the requester favoured when both entries are held.
    always_comb begin
        gnt_a = held_a & (~held_m | (rr_q == REQ_ALU));
        gnt_m = held_m & (~held_a | (rr_q == REQ_MDV));
    end

    // Ready is forced low while clr_n is asserted; otherwise a draining slot may refill.
    assign a_ready = clr_n & (~held_a | gnt_a);
    assign m_ready = clr_n & (~held_m | gnt_m);

    // Writes to register zero are accepted but never stored.
    assign load_a = a_valid & a_ready & (a_addr != '0);
    assign load_m = m_valid & m_ready & (m_addr != '0);

    wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_alu (
        .clk     (clk),
        .clr_n   (clr_n),
        .load_i  (load_a),
        .clear_i (gnt_a),
        .addr_i  (a_addr),
        .data_i  (a_data),
        .valid_o (held_a),
        .addr_o  (hold_addr_a),
        .data_o  (hold_data_a)
    );

    wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_mdv (
        .clk     (clk),
        .clr_n   (clr_n),
        .load_i  (load_m),
        .clear_i (gnt_m),
        .addr_i  (m_addr),
        .data_i  (m_data),
        .valid_o (held_m),
        .addr_o  (hold_addr_m),
        .data_o  (hold_data_m)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        ctrl_writeEnable = gnt_a | gnt_m;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        if (gnt_a) begin
            ctrl_writeReg = hold_addr_a;
            data_writeReg = hold_data_a;
        end else if (gnt_m) begin
            ctrl_writeReg = hold_addr_m;
            data_writeReg = hold_data_m;
        end
    end

    always_comb begin
        pending = '0;
        if (held_a) pending[hold_addr_a] = 1'b1;
        if (held_m) pending[hold_addr_m] = 1'b1;
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_a) begin
            rr_d = REQ_MDV;
        end else if (gnt_m) begin
            rr_d = REQ_ALU;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rr_q <= REQ_ALU;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter against a queue-style reference model.
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 1 << AW;

    logic          clk = 1'b0;
    logic          clr_n;
    logic          a_valid, m_valid;
    logic          a_ready, m_ready;
    logic [AW-1:0] a_addr, m_addr;
    logic [DW-1:0] a_data, m_data;
    logic          ctrl_writeEnable;
    logic [AW-1:0] ctrl_writeReg;
    logic [DW-1:0] data_writeReg;
    logic [NR-1:0] pending;

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk              (clk),
        .clr_n            (clr_n),
        .a_valid          (a_valid),
        .a_ready          (a_ready),
        .a_addr           (a_addr),
        .a_data           (a_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_addr           (m_addr),
        .m_data           (m_data),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .pending          (pending)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: one waiting write per requester, plus who was served last.
    bit            mdl_held [2];
    logic [AW-1:0] mdl_addr [2];
    logic [DW-1:0] mdl_data [2];
    int            last_served;
    logic [DW-1:0] ref_rf [NR];
    logic [DW-1:0] dut_rf [NR];
    int            n_ref_writes;
    int            n_dut_writes;

    function automatic int pick();
        if (mdl_held[0] && mdl_held[1]) return 1 - last_served;
        if (mdl_held[0]) return 0;
        if (mdl_held[1]) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        mdl_held[0] = 1'b0;
        mdl_held[1] = 1'b0;
        last_served = 1;
    endtask

    task automatic step(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input bit mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
        int            g;
        bit            er_a, er_m;
        logic [NR-1:0] ep;
        @(negedge clk);
        a_valid = av; a_addr = aa; a_data = ad;
        m_valid = mv; m_addr = ma; m_data = md;
        #1;
        g    = pick();
        er_a = !mdl_held[0] || (g == 0);
        er_m = !mdl_held[1] || (g == 1);
        ep   = '0;
        for (int r = 0; r < 2; r++) if (mdl_held[r]) ep[mdl_addr[r]] = 1'b1;
        check("a_ready", 64'(a_ready), 64'(er_a));
        check("m_ready", 64'(m_ready), 64'(er_m));
        check("we", 64'(ctrl_writeEnable), 64'(g >= 0));
        check("wreg", 64'(ctrl_writeReg), (g >= 0) ? 64'(mdl_addr[g]) : 64'd0);
        check("wdata", 64'(data_writeReg), (g >= 0) ? 64'(mdl_data[g]) : 64'd0);
        check("pending", 64'(pending), 64'(ep));
        if (ctrl_writeEnable) begin
            dut_rf[ctrl_writeReg] = data_writeReg;
            n_dut_writes++;
        end
        @(posedge clk);
        if (g >= 0) begin
            ref_rf[mdl_addr[g]] = mdl_data[g];
            n_ref_writes++;
            mdl_held[g] = 1'b0;
            last_served = g;
        end
        if (av && er_a && aa != '0) begin
            mdl_held[0] = 1'b1; mdl_addr[0] = aa; mdl_data[0] = ad;
        end
        if (mv && er_m && ma != '0) begin
            mdl_held[1] = 1'b1; mdl_addr[1] = ma; mdl_data[1] = md;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        for (int r = 0; r < NR; r++) begin
            ref_rf[r] = '0;
            dut_rf[r] = '0;
        end
        n_ref_writes = 0;
        n_dut_writes = 0;
        model_reset();
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        m_valid = 1'b0; m_addr = '0; m_data = '0;
        clr_n = 1'b0;
        #12;
        check("rst_a_ready", 64'(a_ready), 64'd0);
        check("rst_m_ready", 64'(m_ready), 64'd0);
        check("rst_we", 64'(ctrl_writeEnable), 64'd0);
        check("rst_wreg", 64'(ctrl_writeReg), 64'd0);
        check("rst_wdata", 64'(data_writeReg), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        @(negedge clk);
        clr_n = 1'b1;

        // Single ALU write becomes visible one cycle after acceptance.
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        #1;
        check("single_we", 64'(ctrl_writeEnable), 64'd1);
        check("single_reg", 64'(ctrl_writeReg), 64'd5);
        check("single_data", 64'(data_writeReg), 64'hDEADBEEF);
        check("single_pend", 64'(pending), 64'h20);
        idle(1);
        #1;
        check("single_pend_clr", 64'(pending), 64'd0);

        // Reset again so both requests arrive with the pointer at its reset value.
        @(negedge clk);
        clr_n = 1'b0;
        model_reset();
        @(negedge clk);
        clr_n = 1'b1;
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
        #1;
        check("simul_first", 64'(ctrl_writeReg), 64'd3);
        idle(1);
        #1;
        check("simul_second", 64'(ctrl_writeReg), 64'd7);
        idle(1);

        // Register zero is accepted but produces nothing.
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF);
        #1;
        check("zero_we", 64'(ctrl_writeEnable), 64'd0);
        check("zero_pend", 64'(pending), 64'd0);

        // Same destination from both: both writes in grant order, last one sticks.
        step(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB);
        idle(3);
        check("same_addr_final", 64'(dut_rf[9]), 64'hB);

        // Streaming: both valid every cycle.
        for (int i = 0; i < 10; i++)
            step(1'b1, AW'(i + 1), 32'h100 + DW'(i), 1'b1, AW'(i + 11), 32'h200 + DW'(i));
        idle(3);

        // Randomised traffic, including occasional register-zero writes.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
        idle(3);

        // Reset while both entries are held: outputs drop at once, nothing written afterwards.
        step(1'b1, 5'd12, 32'hC0FFEE, 1'b1, 5'd13, 32'hBADF00D);
        @(negedge clk);
        a_valid = 1'b0; m_valid = 1'b0;
        #2;
        clr_n = 1'b0;
        #1;
        check("midrst_we", 64'(ctrl_writeEnable), 64'd0);
        check("midrst_pend", 64'(pending), 64'd0);
        check("midrst_a_ready", 64'(a_ready), 64'd0);
        check("midrst_m_ready", 64'(m_ready), 64'd0);
        model_reset();
        @(negedge clk);
        clr_n = 1'b1;
        idle(3);

        for (int r = 0; r < NR; r++) check($sformatf("rf[%0d]", r), 64'(dut_rf[r]), 64'(ref_rf[r]));
        check("write_count", 64'(n_dut_writes), 64'(n_ref_writes));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
